// File: rtl/rv32i_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rv32i_pkg
//  Description : Shared RV32I types for the regfile write-port arbiter slice.
//                Register address/data types, register count and the
//                starvation-FSM state encoding.
//  Revision    : 1.0  initial release
// ============================================================================
package rv32i_pkg;

    localparam int NUM_REGS = 32;
    localparam int REG_AW   = 5;
    localparam int XLEN     = 32;

    typedef logic [REG_AW-1:0] regaddr_t;
    typedef logic [XLEN-1:0]   word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        FORCE = 2'd2
    } arb_state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_scoreboard
//  Description : Busy scoreboard for long-latency destinations plus the
//                outstanding-op counter.
//  Ports       : clk, rst (async active-low)
//                issue_valid/issue_rd   - LL op issued by decode
//                ll_accept/ll_rd        - LL result written back this cycle
//                dec_rs1/rs2/rd         - decode operands to check
//                hazard                 - any decode operand is busy
//                issue_ready            - room for another LL op
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_scoreboard
    import rv32i_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     issue_valid,
    input  regaddr_t issue_rd,
    input  logic     ll_accept,
    input  regaddr_t ll_rd,
    input  regaddr_t dec_rs1,
    input  regaddr_t dec_rs2,
    input  regaddr_t dec_rd,
    output logic     hazard,
    output logic     issue_ready
);

    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0]       outstanding;
    logic [NUM_REGS-1:0] busy;
    logic                issue_fire;

    // Gated by reset so nothing is handed out while the block is held in reset.
    assign issue_ready = rst & (outstanding < CW'(MAX_OUTSTANDING));
    assign issue_fire  = issue_valid & issue_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            outstanding <= '0;
        end else begin
            case ({issue_fire, ll_accept})
                2'b10:   outstanding <= outstanding + CW'(1);
                2'b01:   if (outstanding != '0) outstanding <= outstanding - CW'(1);
                default: outstanding <= outstanding;
            endcase
        end
    end

    // One flop per architectural register; x0 is hard-wired idle.
    // A same-cycle set and clear on one register resolves to set: the new
    // op's result is still owed even though an older one just landed.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_busy
            if (i == 0) begin : g_x0
                assign busy[i] = 1'b0;
            end else begin : g_reg
                logic busy_q;
                always_ff @(posedge clk or negedge rst) begin
                    if (!rst) begin
                        busy_q <= 1'b0;
                    end else if (issue_fire && issue_rd == regaddr_t'(i)) begin
                        busy_q <= 1'b1;
                    end else if (ll_accept && ll_rd == regaddr_t'(i)) begin
                        busy_q <= 1'b0;
                    end
                end
                assign busy[i] = busy_q;
            end
        end
    endgenerate

    // Registered busy only: a register cleared this cycle still reports a hazard.
    assign hazard = busy[dec_rs1] | busy[dec_rs2] | busy[dec_rd];

endmodule
`default_nettype wire

// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : regfile_wb_arbiter
//  Description : Owns the single regfile write port. Pipeline writeback has
//                fixed priority; the long-latency unit gets the port when WB
//                leaves it free. Tracks LL destinations for hazard detection
//                and requests a WB bubble when LL has been starved too long.
//  Ports       : clk, rst (async active-low)
//                wb_valid/wb_rd/wb_data        - pipeline writeback
//                ll_valid/ll_rd/ll_data/ll_ready - LL result handshake
//                issue_valid/issue_rd/issue_ready - LL issue from decode
//                dec_rs1/dec_rs2/dec_rd/hazard  - decode hazard query
//                stall_req                      - registered bubble request
//                rf_we/rf_writeaddr/rf_writedata - regfile write port
//  Revision    : 1.0  initial release
// ============================================================================
module regfile_wb_arbiter
    import rv32i_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int MAX_WAIT        = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     wb_valid,
    input  regaddr_t wb_rd,
    input  word_t    wb_data,
    input  logic     ll_valid,
    input  regaddr_t ll_rd,
    input  word_t    ll_data,
    output logic     ll_ready,
    input  logic     issue_valid,
    input  regaddr_t issue_rd,
    output logic     issue_ready,
    input  regaddr_t dec_rs1,
    input  regaddr_t dec_rs2,
    input  regaddr_t dec_rd,
    output logic     hazard,
    output logic     stall_req,
    output logic     rf_we,
    output regaddr_t rf_writeaddr,
    output word_t    rf_writedata
);

    logic       occupied;
    logic       ll_grant;
    arb_state_t state, state_next;
    logic [7:0] wait_cnt, wait_cnt_next;

    // ------------------------------------------------------------------
    // Grant mux. A WB write to x0 is a no-op and leaves the port free.
    // ------------------------------------------------------------------
    assign occupied = wb_valid & (wb_rd != '0);
    assign ll_ready = rst & ll_valid & ~occupied;
    assign ll_grant = ll_ready & ~occupied;

    // LL results for x0 are consumed without a write.
    assign rf_we        = rst & (occupied | (ll_grant & (ll_rd != '0)));
    assign rf_writeaddr = ll_grant ? ll_rd   : wb_rd;
    assign rf_writedata = ll_grant ? ll_data : wb_data;

    regfile_scoreboard #(
        .MAX_OUTSTANDING (MAX_OUTSTANDING)
    ) u_scoreboard (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .ll_accept   (ll_ready),
        .ll_rd       (ll_rd),
        .dec_rs1     (dec_rs1),
        .dec_rs2     (dec_rs2),
        .dec_rd      (dec_rd),
        .hazard      (hazard),
        .issue_ready (issue_ready)
    );

    // ------------------------------------------------------------------
    // Starvation FSM: wait_cnt counts consecutive cycles LL has been
    // blocked by WB. Reaching MAX_WAIT blocked cycles moves to FORCE.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 8'd0;
            stall_req <= 1'b0;
        end else begin
            state     <= state_next;
            wait_cnt  <= wait_cnt_next;
            // Registered so it is high exactly while the FSM sits in FORCE.
            stall_req <= (state_next == FORCE);
        end
    end

    always_comb begin
        state_next    = state;
        wait_cnt_next = wait_cnt;
        case (state)
            IDLE: begin
                if (ll_valid && occupied) begin
                    state_next    = WAIT;
                    wait_cnt_next = 8'd1;
                end else begin
                    wait_cnt_next = 8'd0;
                end
            end
            WAIT: begin
                if (ll_ready || !ll_valid) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end else if (wait_cnt == 8'(MAX_WAIT - 1)) begin
                    state_next    = FORCE;
                end else begin
                    wait_cnt_next = wait_cnt + 8'd1;
                end
            end
            FORCE: begin
                if (ll_ready || !ll_valid) begin
                    state_next    = IDLE;
                    wait_cnt_next = 8'd0;
                end
            end
            default: begin
                state_next    = IDLE;
                wait_cnt_next = 8'd0;
            end
        endcase
    end

endmodule
`default_nettype wire
